// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//   Four-source, rising-edge-triggered, fixed-priority interrupt controller.
//   Source 0 has the highest priority. One request is presented to the CPU at
//   a time, and there is no nesting. The CPU accepts a request on the edge
//   after int_req rises, and it ends service with an int_ret pulse.
//
//   Registers (cfg_addr): 0 CTRL  {mask[3:0], spare[2:0], global_en}
//                         1 VBASE vector base, vector = VBASE + 4*id
//                         2 PEND  {4'b0, pend[3:0]}, write 1 to clear
//                         3 STATUS {4'b0, int_req, id[1:0], in_service}, RO
//
//   Ports:
//     clock, reset_n         clock and async active-low reset
//     irq_src[3:0]           interrupt sources (edge triggered)
//     cfg_w_en/addr/w_data   register write port (sampled at posedge)
//     cfg_r_data             combinational register read
//     int_ret                CPU interrupt-return pulse
//     int_req, int_en, int_vec  request, CTRL mirror, handler address
//
//   Optional build macro: INTC_SYNC_EN adds a 2-flop synchronizer on irq_src.
// ---------------------------------------------------------------------------
module interrupt_controller (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] irq_src,
    input  logic       cfg_w_en,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_w_data,
    output logic [7:0] cfg_r_data,
    input  logic       int_ret,
    output logic       int_req,
    output logic [7:0] int_en,
    output logic [7:0] int_vec
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_VBASE  = 2'd1;
    localparam logic [1:0] A_PEND   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    state_e     state_q, state_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] vbase_q, vbase_d;
    logic [7:0] vec_q, vec_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] id_q, id_d;
    logic [3:0] src_q;
    logic [3:0] src_in;
    logic [3:0] rise;
    logic [3:0] elig;
    logic [1:0] pick_id;

`ifdef INTC_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = irq_src;
`endif

    // The sample register resets to 0, so a source that is held high through
    // reset release is seen as one edge on the first clock.
    assign rise = src_in & ~src_q;
    assign elig = pend_q & ctrl_q[7:4];

    // Fixed priority: the lowest index wins.
    always_comb begin
        if (elig[0])      pick_id = 2'd0;
        else if (elig[1]) pick_id = 2'd1;
        else if (elig[2]) pick_id = 2'd2;
        else              pick_id = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        vbase_d = vbase_q;
        vec_d   = vec_q;
        id_d    = id_q;
        pend_d  = pend_q;

        if (cfg_w_en) begin
            case (cfg_addr)
                A_CTRL:  ctrl_d  = cfg_w_data;
                A_VBASE: vbase_d = cfg_w_data;
                A_PEND:  pend_d  = pend_q & ~cfg_w_data[3:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (ctrl_q[0] && (elig != 4'd0)) begin
                    state_d = REQ;
                    id_d    = pick_id;
                    vec_d   = vbase_q + {4'd0, pick_id, 2'b00};  // wraps mod 256
                end
            end
            REQ: begin
                // The id stays latched here even when the masks change.
                if (ctrl_q[0]) begin
                    state_d      = SERVICE;
                    pend_d[id_q] = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (int_ret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new edge takes priority over any clear applied in the same cycle.
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ctrl_q  <= 8'h00;
            vbase_q <= 8'hF0;
            vec_q   <= 8'hF0;
            pend_q  <= 4'd0;
            id_q    <= 2'd0;
            src_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            vbase_q <= vbase_d;
            vec_q   <= vec_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            src_q   <= src_in;
        end
    end

    assign int_req = (state_q == REQ) && ctrl_q[0];
    assign int_en  = ctrl_q;
    assign int_vec = vec_q;

    always_comb begin
        case (cfg_addr)
            A_CTRL:   cfg_r_data = ctrl_q;
            A_VBASE:  cfg_r_data = vbase_q;
            A_PEND:   cfg_r_data = {4'd0, pend_q};
            A_STATUS: cfg_r_data = {4'd0, int_req, id_q, state_q == SERVICE};
            default:  cfg_r_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//   Directed stimulus. A behavioural model tracks the controller as a phase
//   number (0 idle, 1 requesting, 2 in service), a pending bit list, and plain
//   integer vector arithmetic. Every falling edge compares all outputs
//   against the model. Hand-computed literal values pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] irq_src = 4'd0;
    logic       cfg_w_en = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_w_data = 8'd0;
    logic [7:0] cfg_r_data;
    logic       int_ret = 1'b0;
    logic       int_req;
    logic [7:0] int_en;
    logic [7:0] int_vec;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .irq_src    (irq_src),
        .cfg_w_en   (cfg_w_en),
        .cfg_addr   (cfg_addr),
        .cfg_w_data (cfg_w_data),
        .cfg_r_data (cfg_r_data),
        .int_ret    (int_ret),
        .int_req    (int_req),
        .int_en     (int_en),
        .int_vec    (int_vec)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int       m_phase = 0;
    int       m_id = 0;
    bit [7:0] m_ctrl = 8'h00;
    bit [7:0] m_vbase = 8'hF0;
    bit [7:0] m_vec = 8'hF0;
    bit [3:0] m_pend = 4'd0;
    bit [3:0] m_prev = 4'd0;
    bit [3:0] m_src;
    bit [3:0] n_pend;
    int       n_phase;
    int       found;
`ifdef INTC_SYNC_EN
    bit [3:0] m_s1 = 4'd0;
    bit [3:0] m_s2 = 4'd0;
`endif

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_id = 0; m_ctrl = 8'h00; m_vbase = 8'hF0;
            m_vec = 8'hF0; m_pend = 4'd0; m_prev = 4'd0;
`ifdef INTC_SYNC_EN
            m_s1 = 4'd0; m_s2 = 4'd0;
`endif
        end else begin
`ifdef INTC_SYNC_EN
            m_src = m_s2; m_s2 = m_s1; m_s1 = irq_src;
`else
            m_src = irq_src;
`endif
            n_phase = m_phase;
            n_pend  = m_pend;
            if (cfg_w_en && cfg_addr == 2'd2)
                for (int i = 0; i < 4; i++) if (cfg_w_data[i]) n_pend[i] = 1'b0;
            if (m_phase == 0 && m_ctrl[0]) begin
                found = -1;
                for (int i = 0; i < 4; i++)
                    if (found < 0 && m_pend[i] && m_ctrl[4+i]) found = i;
                if (found >= 0) begin
                    n_phase = 1;
                    m_id    = found;
                    m_vec   = 8'((int'(m_vbase) + 4 * found) % 256);
                end
            end else if (m_phase == 1) begin
                if (m_ctrl[0]) begin
                    n_phase = 2;
                    n_pend[m_id] = 1'b0;
                end else begin
                    n_phase = 0;
                end
            end else if (m_phase == 2 && int_ret) begin
                n_phase = 0;
            end
            for (int i = 0; i < 4; i++) if (m_src[i] && !m_prev[i]) n_pend[i] = 1'b1;
            if (cfg_w_en && cfg_addr == 2'd0) m_ctrl = cfg_w_data;
            if (cfg_w_en && cfg_addr == 2'd1) m_vbase = cfg_w_data;
            m_prev  = m_src;
            m_pend  = n_pend;
            m_phase = n_phase;
        end
    end

    function automatic bit m_req();
        return (m_phase == 1) && m_ctrl[0];
    endfunction

    function automatic bit [7:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_ctrl;
            2'd1:    return m_vbase;
            2'd2:    return {4'd0, m_pend};
            default: return 8'((m_req() ? 8 : 0) + 2 * m_id + (m_phase == 2 ? 1 : 0));
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, exp);
        end
    endtask

    // One compare process against the model on every falling edge.
    always @(negedge clock) begin
        cmp("model int_req", {7'd0, int_req}, {7'd0, m_req()});
        cmp("model int_en", int_en, m_ctrl);
        cmp("model int_vec", int_vec, m_vec);
        cmp("model cfg_r_data", cfg_r_data, m_read(cfg_addr));
    end

    // ---------------- directed stimulus ----------------
    // Inputs change 1 time unit after a rising edge. Read checks add 1 each,
    // and at most three are used per cycle so they finish before the falling edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_w_en = 1'b1; cfg_addr = a; cfg_w_data = d;
        cyc();
        cfg_w_en = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [1:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        cmp(nm, cfg_r_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset_n = 1'b0;
        #2;
        cmp("reset int_vec", int_vec, 8'hF0);
        cmp("reset int_en", int_en, 8'h00);
        cmp("reset int_req", {7'd0, int_req}, 8'h00);
        rdchk("reset VBASE", 2'd1, 8'hF0);
        cyc();
        reset_n = 1'b1;
        cfg_addr = 2'd0;

        // Single source 2 with VBASE 0x80.
        wr(2'd0, 8'hF1);
        wr(2'd1, 8'h80);
        irq_src = 4'b0100; cyc(); irq_src = 4'd0;
        rdchk("s2 PEND set", 2'd2, 8'h04);
        cmp("s2 no req yet", {7'd0, int_req}, 8'h00);
        cyc();
        cmp("s2 int_req", {7'd0, int_req}, 8'h01);
        cmp("s2 int_vec", int_vec, 8'h88);
        cyc();
        cmp("s2 req dropped", {7'd0, int_req}, 8'h00);
        rdchk("s2 STATUS", 2'd3, 8'h05);
        rdchk("s2 PEND clear", 2'd2, 8'h00);
        int_ret = 1'b1; cyc(); int_ret = 1'b0;

        // Sources 3 and 1 together: 1 first, then 3.
        irq_src = 4'b1010; cyc(); irq_src = 4'd0;
        cyc();
        cmp("pri src1 req", {7'd0, int_req}, 8'h01);
        cmp("pri src1 vec", int_vec, 8'h84);
        cyc();
        rdchk("pri PEND left", 2'd2, 8'h08);
        rdchk("pri STATUS", 2'd3, 8'h03);
        int_ret = 1'b1; cyc(); int_ret = 1'b0;
        cyc();
        cmp("pri src3 req", {7'd0, int_req}, 8'h01);
        cmp("pri src3 vec", int_vec, 8'h8C);
        cyc();
        int_ret = 1'b1; cyc(); int_ret = 1'b0;

        // Vector wrap-around.
        wr(2'd1, 8'hFC);
        irq_src = 4'b0010; cyc(); irq_src = 4'd0;
        cyc();
        cmp("wrap vec", int_vec, 8'h00);
        cyc();

        // No nesting while in service.
        irq_src = 4'b0001; cyc(); irq_src = 4'd0;
        cyc(); cyc();
        cmp("nest blocked", {7'd0, int_req}, 8'h00);
        rdchk("nest PEND", 2'd2, 8'h01);
        int_ret = 1'b1; cyc(); int_ret = 1'b0;
        cmp("nest idle", {7'd0, int_req}, 8'h00);
        cyc();
        cmp("nest req after ret", {7'd0, int_req}, 8'h01);
        cmp("nest vec", int_vec, 8'hFC);
        int_ret = 1'b1; cyc(); int_ret = 1'b0;   // int_ret in REQ is ignored
        cyc();
        rdchk("ret ignored in REQ", 2'd3, 8'h01);
        int_ret = 1'b1; cyc(); int_ret = 1'b0;

        // Global enable off, then on.
        wr(2'd0, 8'h10);
        irq_src = 4'b0001; cyc(); irq_src = 4'd0;
        rdchk("gdis PEND", 2'd2, 8'h01);
        cyc(); cyc();
        cmp("gdis no req", {7'd0, int_req}, 8'h00);
        wr(2'd0, 8'h11);
        cmp("gen same cycle", {7'd0, int_req}, 8'h00);
        cyc();
        cmp("gen req", {7'd0, int_req}, 8'h01);
        cyc();
        int_ret = 1'b1; cyc(); int_ret = 1'b0;

        // A pending bit cleared before enabling gives no request.
        wr(2'd0, 8'h10);
        irq_src = 4'b0001; cyc(); irq_src = 4'd0;
        wr(2'd2, 8'h01);
        rdchk("pclr PEND", 2'd2, 8'h00);
        wr(2'd0, 8'h11);
        cyc(); cyc();
        cmp("pclr no req", {7'd0, int_req}, 8'h00);

        // A new edge wins over a same-cycle clear (source 1 masked off).
        cfg_w_en = 1'b1; cfg_addr = 2'd2; cfg_w_data = 8'h02; irq_src = 4'b0010;
        cyc();
        cfg_w_en = 1'b0; irq_src = 4'd0;
        rdchk("set wins", 2'd2, 8'h02);

        // Global disable while in REQ returns to IDLE with PEND kept.
        wr(2'd0, 8'hF1);
        wr(2'd0, 8'hF0);
        cmp("req gdis int_req", {7'd0, int_req}, 8'h00);
        rdchk("req gdis STATUS", 2'd3, 8'h02);
        cyc();
        rdchk("req abort PEND", 2'd2, 8'h02);

        // A mask change in REQ keeps the latched id.
        wr(2'd0, 8'hF1);
        wr(2'd0, 8'h01);
        cmp("mask chg req", {7'd0, int_req}, 8'h01);
        cyc();
        rdchk("mask chg STATUS", 2'd3, 8'h03);
        rdchk("mask chg PEND", 2'd2, 8'h00);
        int_ret = 1'b1; cyc(); int_ret = 1'b0;
        wr(2'd3, 8'hFF);
        rdchk("STATUS ro", 2'd3, 8'h02);

        // Reset in the middle of service, with source 0 held high throughout.
        wr(2'd0, 8'h11);
        irq_src = 4'b0001; cyc(); cyc(); cyc();
        rdchk("pre-reset STATUS", 2'd3, 8'h01);
        reset_n = 1'b0;
        #1;
        cmp("mid rst int_req", {7'd0, int_req}, 8'h00);
        cmp("mid rst int_en", int_en, 8'h00);
        cmp("mid rst int_vec", int_vec, 8'hF0);
        cyc(); cyc();
        reset_n = 1'b1;
        rdchk("post rst STATUS", 2'd3, 8'h00);
        rdchk("post rst PEND", 2'd2, 8'h00);
        cyc();
        rdchk("held src edge", 2'd2, 8'h01);
        irq_src = 4'd0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
